// File: rtl/rvc_aligner.sv
// Realigns word-aligned 32-bit fetch words into 16/32-bit instructions on halfword
// boundaries, presenting each one with its PC through a registered valid/ready slot.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// ALIGNED | no halfword buffered; next instruction starts at a fetch word
// HELD    | hold_r buffers the low half of the next instruction
// SKIP    | redirect to an odd halfword; the next fetch word's low half is dropped
module rvc_aligner (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        fetch_valid_i,
  input  logic [31:0] fetch_data_i,
  input  logic [31:0] fetch_pc_i,
  output logic        fetch_ready_o,
  input  logic        flush_i,
  input  logic [31:0] flush_pc_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  input  logic        instr_ready_i
);

  typedef enum logic [1:0] {
    ALIGNED = 2'd0,
    HELD    = 2'd1,
    SKIP    = 2'd2
  } state_t;

  state_t      state_r;
  logic [15:0] hold_r;
  logic [31:0] hold_pc_r;

  logic        adv;
  logic        hc;
  logic        fetch_acc;
  logic [31:0] fetch_pc_hi;

  // Only bit 1 of the redirect target matters here; fetch handles the word part.
  logic unused_flush_bits;
  assign unused_flush_bits = ^{flush_pc_i[31:2], flush_pc_i[0]};

  assign adv         = !instr_valid_o || instr_ready_i;
  assign hc          = hold_r[1:0] != 2'b11;
  assign fetch_pc_hi = fetch_pc_i + 32'd2;
  assign fetch_acc   = fetch_valid_i && fetch_ready_o;

  always_comb begin
    fetch_ready_o = 1'b0;
    if (!rst_ni || flush_i) begin
      fetch_ready_o = 1'b0;
    end else if (state_r == SKIP) begin
      fetch_ready_o = 1'b1;
    end else if (state_r == HELD && hc) begin
      fetch_ready_o = 1'b0;
    end else begin
      fetch_ready_o = adv;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r       <= ALIGNED;
      hold_r        <= 16'h0;
      hold_pc_r     <= 32'h0;
      instr_valid_o <= 1'b0;
      instr_o       <= 32'h0;
      instr_pc_o    <= 32'h0;
    end else if (flush_i) begin
      instr_valid_o <= 1'b0;
      hold_r        <= 16'h0;
      hold_pc_r     <= 32'h0;
      state_r       <= flush_pc_i[1] ? SKIP : ALIGNED;
    end else begin
      // Default: slot drains when taken; any emission below overrides this.
      if (instr_ready_i) begin
        instr_valid_o <= 1'b0;
      end
      case (state_r)
        ALIGNED: begin
          if (fetch_acc) begin
            instr_valid_o <= 1'b1;
            instr_pc_o    <= fetch_pc_i;
            if (fetch_data_i[1:0] != 2'b11) begin
              instr_o   <= {16'h0, fetch_data_i[15:0]};
              hold_r    <= fetch_data_i[31:16];
              hold_pc_r <= fetch_pc_hi;
              state_r   <= HELD;
            end else begin
              instr_o <= fetch_data_i;
            end
          end
        end
        HELD: begin
          if (hc) begin
            if (adv) begin
              instr_valid_o <= 1'b1;
              instr_o       <= {16'h0, hold_r};
              instr_pc_o    <= hold_pc_r;
              state_r       <= ALIGNED;
            end
          end else if (fetch_acc) begin
            instr_valid_o <= 1'b1;
            instr_o       <= {fetch_data_i[15:0], hold_r};
            instr_pc_o    <= hold_pc_r;
            hold_r        <= fetch_data_i[31:16];
            hold_pc_r     <= fetch_pc_hi;
          end
        end
        SKIP: begin
          if (fetch_acc) begin
            hold_r    <= fetch_data_i[31:16];
            hold_pc_r <= fetch_pc_hi;
            state_r   <= HELD;
          end
        end
        default: begin
          state_r <= ALIGNED;
        end
      endcase
    end
  end

endmodule

// File: doc/rvc_aligner.md
# rvc_aligner

Instruction realigner between the fetch stage and `rvc_expander`. It takes word-aligned 32-bit fetch words and cuts them into individual instructions on 16-bit boundaries. It keeps the leftover halfword for compressed instructions and for 32-bit instructions that straddle two fetch words. Each instruction goes out through a registered valid/ready slot together with its PC; the raw instruction then feeds the expander.

## Interface
Parameters:
- none.

Ports:
- `clk_i` input 1: clock. One clock domain.
- `rst_ni` input 1: reset, asynchronous, active-low.
- `fetch_valid_i` input 1: fetch word valid.
- `fetch_data_i` input 32: fetch word; bits [15:0] are at `fetch_pc_i`, bits [31:16] at `fetch_pc_i+2`.
- `fetch_pc_i` input 32: word address of `fetch_data_i`; bits [1:0] are always 0.
- `fetch_ready_o` output 1: the fetch word is accepted when this and `fetch_valid_i` are both high at a clock edge.
- `flush_i` input 1: redirect; discard all buffered state.
- `flush_pc_i` input 32: redirect target; bit 0 = 0, bit 1 may be 1.
- `instr_valid_o` output 1: output slot holds an instruction.
- `instr_o` output 32: raw instruction. A 16-bit instruction is zero-extended to `{16'h0, half}`.
- `instr_pc_o` output 32: PC of `instr_o`.
- `instr_ready_i` input 1: downstream takes the slot.

## Operation
- Internal state:
  - `state_r`: ALIGNED, HELD or SKIP.
  - `hold_r[15:0]` and `hold_pc_r[31:0]`: the buffered halfword and its PC.
  - Output slot registers: `instr_valid_o`, `instr_o`, `instr_pc_o`.
- Helper terms:
  - `adv` = !instr_valid_o || instr_ready_i (the slot can be reloaded this cycle).
  - `hc` = hold_r[1:0] != 2'b11 (the held halfword is a compressed instruction).
- `fetch_ready_o` rules:
  - 0 while rst_ni = 0 or flush_i = 1.
  - In SKIP: 1.
  - In HELD with hc: 0.
  - Otherwise: equal to `adv`.
- ALIGNED, on fetch accept (word W at PC P):
  - If W[1:0] != 11: emit `{16'h0, W[15:0]}` at P; hold_r = W[31:16], hold_pc_r = P+2; go to HELD.
  - If W[1:0] == 11: emit W at P; stay ALIGNED.
- HELD with hc, on `adv`: emit `{16'h0, hold_r}` at hold_pc_r; no fetch is consumed; go to ALIGNED.
- HELD with !hc, on fetch accept: emit `{W[15:0], hold_r}` at hold_pc_r; hold_r = W[31:16], hold_pc_r = P+2; stay HELD.
- SKIP, on fetch accept: discard W[15:0]; hold_r = W[31:16], hold_pc_r = P+2; go to HELD; no emission this cycle.
- No qualifying event: the slot clears (instr_valid_o = 0) if instr_ready_i = 1, otherwise it holds its value; state is unchanged.
- Flush:
  - Has priority over everything else in the same cycle.
  - Next cycle: instr_valid_o = 0; state = flush_pc_i[1] ? SKIP : ALIGNED.
  - Fetch inputs in the flush cycle are ignored.
- Fetch duties after a flush:
  - Fetch resumes at `{flush_pc_i[31:2], 2'b00}`. The aligner does not check `fetch_pc_i`.
  - Fetch keeps `fetch_data_i` and `fetch_pc_i` stable while valid and not ready.
- PC arithmetic is 32-bit modulo 2^32: P+2 wraps from 0xFFFF_FFFE to 0x0000_0000.
- No instruction-legality checking; illegal encodings are the expander's job.

## Timing
- Reset (async assert, sync-released state):
  - state_r = ALIGNED; hold_r = 0; hold_pc_r = 0.
  - instr_valid_o = 0; instr_o = 0; instr_pc_o = 0.
  - fetch_ready_o = 0 while in reset.
  - A reset mid-straddle discards the held half.
- Latency:
  - 1 cycle from fetch accept to instr_valid_o.
  - A held compressed halfword is emitted in the cycle after `adv`, with no fetch needed.
- Throughput with instr_ready_i = 1:
  - 1 instruction per cycle.
  - A word of two compressed halves takes 2 cycles and 1 fetch.
  - SKIP costs 1 bubble.
- Backpressure: while instr_valid_o = 1 and instr_ready_i = 0, the outputs are stable and fetch_ready_o = 0.
- Simultaneous instr_ready_i and a new emission: the slot is reloaded in the same edge with no bubble.

## Test plan
- **All 32-bit, back-to-back.** Words 0x00000013 @0x0 and 0x00100093 @0x4, instr_ready_i = 1 → outputs 0x00000013 @0x0, then 0x00100093 @0x4, on consecutive cycles; state stays ALIGNED.
- **Compressed pair.** Word 0x45854501 @0x0 → outputs 0x00004501 @0x0, then 0x00004585 @0x2. fetch_ready_o = 0 in the second cycle.
- **Straddling 32-bit.** Words 0x00134501 @0x0 and 0x00010000 @0x4 → outputs 0x00004501 @0x0, 0x00000013 @0x2, 0x00000001 @0x6.
- **Flush to odd halfword.** flush_pc_i = 0x102, then word 0x45854501 @0x100 → single output 0x00004585 @0x102; 0x4501 is never emitted.
- **Backpressure.** instr_ready_i = 0 for 3 cycles with a valid output → instr_o, instr_pc_o and instr_valid_o stay constant; fetch_ready_o = 0; no word is lost after release.
- **Flush and reset during straddle.**
  - In HELD with !hc (after word 0x00134501 @0x0, before word 0x00010000 @0x4 arrives), pulse flush_i with flush_pc_i = 0x40 → instr_valid_o = 0 next cycle. Then word 0x00000013 @0x40 gives 0x00000013 @0x40.
  - Repeat with rst_ni pulsed low instead of flush_i → same empty result.
